// File: rtl/powlib_busarbfifo.sv
// Round-robin arbiter over B_WRS write channels feeding a single FIFO.
// Beats whose address falls outside [B_BASE, B_BASE+B_SIZE) are granted and dropped.
module powlib_busarbfifo #(
    parameter int B_WRS  = 4,
    parameter int B_AW   = 8,
    parameter int B_DW   = 32,
    parameter int B_BASE = 0,
    parameter int B_SIZE = 16,
    parameter int D      = 8,
    parameter int NFT    = D - 2,
    parameter int CW     = 8,
    localparam int SW    = (B_WRS > 2) ? $clog2(B_WRS) : 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [B_WRS*B_DW-1:0] wrdatas,
    input  logic [B_WRS*B_AW-1:0] wraddrs,
    input  logic [B_WRS-1:0]      wrvlds,
    output logic [B_WRS-1:0]      wrrdys,
    output logic                  wrnf,
    output logic [B_DW-1:0]       rddata,
    output logic [B_AW-1:0]       rdaddr,
    output logic [SW-1:0]         rdsrc,
    output logic                  rdvld,
    input  logic                  rdrdy,
    output logic                  errpls,
    output logic [CW-1:0]         errcnt
);

    localparam int AW = $clog2(D);
    localparam int EW = B_DW + B_AW + SW;

    localparam logic [SW:0]   NWRS  = (SW+1)'(B_WRS);
    localparam logic [AW:0]   DFULL = (AW+1)'(D);
    localparam logic [AW:0]   NFTC  = (AW+1)'(NFT);
    localparam logic [B_AW:0] WLO   = (B_AW+1)'(B_BASE);
    localparam logic [B_AW:0] WHI   = (B_AW+1)'(B_BASE + B_SIZE);

    logic [SW-1:0]   rrptr_q;
    logic [AW-1:0]   wrptr_q, rdptr_q;
    logic [AW:0]     count_q;
    logic            errpls_q;
    logic [CW-1:0]   errcnt_q;
    logic [EW-1:0]   mem [D];

    logic [SW:0]     cand;
    logic            found;
    logic [SW-1:0]   widx;
    logic [SW-1:0]   rrnext;
    logic [B_AW-1:0] waddr;
    logic [B_DW-1:0] wdata;
    logic            inwin, full, grant, wr_en, rd_en, err_evt;

    // Scan upward from the round-robin pointer, wrapping modulo B_WRS.
    always_comb begin
        found = 1'b0;
        widx  = '0;
        cand  = '0;
        for (int k = 0; k < B_WRS; k++) begin
            cand = {1'b0, rrptr_q} + (SW+1)'(k);
            if (cand >= NWRS) begin
                cand = cand - NWRS;
            end
            if (!found && wrvlds[cand[SW-1:0]]) begin
                found = 1'b1;
                widx  = cand[SW-1:0];
            end
        end
    end

    always_comb begin
        waddr   = wraddrs[int'(widx)*B_AW +: B_AW];
        wdata   = wrdatas[int'(widx)*B_DW +: B_DW];
        inwin   = ({1'b0, waddr} >= WLO) && ({1'b0, waddr} < WHI);
        full    = (count_q == DFULL);
        // A full FIFO blocks only in-window winners; dropped beats always drain.
        grant   = rst && found && (!inwin || !full);
        wr_en   = grant && inwin;
        err_evt = grant && !inwin;
        rd_en   = rdvld && rdrdy;
        wrrdys  = '0;
        if (grant) begin
            wrrdys[widx] = 1'b1;
        end
        if ({1'b0, widx} == NWRS - 1'b1) begin
            rrnext = '0;
        end else begin
            rrnext = widx + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rrptr_q  <= '0;
            wrptr_q  <= '0;
            rdptr_q  <= '0;
            count_q  <= '0;
            errpls_q <= 1'b0;
            errcnt_q <= '0;
        end else begin
            if (grant) begin
                rrptr_q <= rrnext;
            end
            if (wr_en) begin
                wrptr_q <= wrptr_q + 1'b1;
            end
            if (rd_en) begin
                rdptr_q <= rdptr_q + 1'b1;
            end
            case ({wr_en, rd_en})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
            errpls_q <= err_evt;
            if (err_evt && (errcnt_q != '1)) begin
                errcnt_q <= errcnt_q + 1'b1;
            end
        end
    end

    // Storage carries no reset; contents are meaningless while rdvld is low.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wrptr_q] <= {wdata, waddr, widx};
        end
    end

    always_comb begin
        {rddata, rdaddr, rdsrc} = mem[rdptr_q];
        rdvld  = (count_q != '0);
        wrnf   = (count_q >= NFTC);
        errpls = errpls_q;
        errcnt = errcnt_q;
    end

endmodule

// File: doc/powlib_busarbfifo.md
POWLIB_BUSARBFIFO -- requirements
Module: powlib_busarbfifo

Interface
REQ-001 Parameter B_WRS, default 4: number of write channels, 2..16.
REQ-002 Parameter B_AW, default 8: address width.
REQ-003 Parameter B_DW, default 32: data width.
REQ-004 Parameter B_BASE, default 0: inclusive lower bound of the accepted address window.
REQ-005 Parameter B_SIZE, default 16: window size; the window is [B_BASE, B_BASE+B_SIZE), computed in B_AW+1 bits with no wrap.
REQ-006 Parameter D, default 8: FIFO depth, a power of two, minimum 2.
REQ-007 Parameter NFT, default D-2: nearly-full threshold in entries.
REQ-008 Parameter CW, default 8: error counter width; localparam SW = max(1, clog2(B_WRS)).
REQ-009 clk  input  1  sole clock; all state updates on the rising edge.
REQ-010 rst  input  1  asynchronous, active-low reset.
REQ-011 wrdatas  input  B_WRS*B_DW  per-channel write data; channel i occupies bits [i*B_DW +: B_DW].
REQ-012 wraddrs  input  B_WRS*B_AW  per-channel write address, packed the same way.
REQ-013 wrvlds  input  B_WRS  per-channel valid.
REQ-014 wrrdys  output  B_WRS  per-channel ready (grant), combinational.
REQ-015 wrnf  output  1  nearly full: count >= NFT.
REQ-016 rddata  output  B_DW  head entry data.
REQ-017 rdaddr  output  B_AW  head entry address.
REQ-018 rdsrc  output  SW  channel index that wrote the head entry.
REQ-019 rdvld  output  1  head entry valid.
REQ-020 rdrdy  input  1  consumer ready.
REQ-021 errpls  output  1  one-cycle pulse marking an out-of-window beat that was dropped.
REQ-022 errcnt  output  CW  saturating count of dropped beats.

Function
REQ-023 A beat transfers on channel i in a cycle where wrvlds[i] and wrrdys[i] are both high; a read transfer occurs where rdvld and rdrdy are both high.
REQ-024 At most one wrrdys bit is high per cycle; the winner is the first valid channel found searching upward, modulo B_WRS, from round-robin pointer P.
REQ-025 If the winner's address is in-window and count == D, all wrrdys bits are low, the next channel is not tried, and P holds.
REQ-026 A simultaneous read does not free space for a write in the same cycle.
REQ-027 If the winner's address is out-of-window, it is granted regardless of FIFO state, its beat is discarded, errpls is high on the next cycle, and errcnt increments, saturating at 2^CW-1.
REQ-028 After any grant to channel i, P becomes (i+1) mod B_WRS; with no grant, P holds.
REQ-029 An in-window granted beat is written with {data, addr, i} into the FIFO at the write pointer.
REQ-030 rdvld is high when count > 0, and a beat accepted in cycle N is presented no earlier than cycle N+1 (latency 1).
REQ-031 rddata, rdaddr and rdsrc are stable while rdvld is high and rdrdy is low.
REQ-032 On a read, the head advances, and the next entry (if any) is presented in the following cycle with no bubble.
REQ-033 Write and read pointers are log2(D) bits and wrap from D-1 to 0.
REQ-034 count is log2(D)+1 bits: +1 on write only, -1 on read only, unchanged on both or neither.
REQ-035 When count == 0 (empty), rdvld is low and rdrdy is ignored.
REQ-036 Entry order is acceptance order; no reordering occurs across channels.
REQ-037 wrrdys depends only on wrvlds, wraddrs, P and count, never on rdrdy.

Reset
REQ-038 While rst is low: P=0, pointers=0, count=0, rdvld=0, wrrdys=0, wrnf=0, errpls=0, errcnt=0.
REQ-039 Reset assertion mid-operation discards all FIFO contents immediately, asynchronously.
REQ-040 FIFO storage is not reset; rddata, rdaddr and rdsrc are don't-care while rdvld is low.
REQ-041 After rst deasserts, the first grant is possible on the first rising edge.

Verification
REQ-042 Round-robin: all 4 channels valid continuously with in-window addresses and rdrdy=1 -> grants in order 0,1,2,3,0,..., and rdsrc follows the same order starting one cycle after the first grant.
REQ-043 Full: rdrdy=0, channel 2 streams addr 3 -> 8 beats accepted, then wrrdys=0; wrnf rises when count reaches 6; one read frees exactly one slot on the next cycle.
REQ-044 Window: channel 1 writes addr 16 with B_BASE=0 and B_SIZE=16 -> beat granted and not enqueued, errpls=1 for one cycle, errcnt=1; addr 15 -> enqueued.
REQ-045 Saturation: CW=2, five out-of-window beats -> errcnt reads 1,2,3,3,3.
REQ-046 Reset: with 5 entries queued, rst pulled low asynchronously between edges -> rdvld=0 and count=0 immediately; after release, the first new write appears with rdvld=1 one cycle later.
REQ-047 Backpressure: rdrdy toggling randomly while all channels stream -> no beat is lost or duplicated, and per-channel order is preserved.
